// File: rtl/restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_CHK_EN compiles in a divide-by-zero early exit with err flag.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one restoring step per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, result valid
module restoring_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_qsh;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_carry;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_q;
  logic             w_last;

  // r_qsh starts as the dividend and fills with quotient bits from the LSB side
  assign w_shift    = {r_rem, r_qsh[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} + {2'b01, ~r_dvs} + (WIDTH+2)'(1);
  assign w_carry    = w_trial[WIDTH+1];
  assign w_next_rem = w_carry ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_next_q   = {r_qsh[WIDTH-2:0], w_carry};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_CHK_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_qsh   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_qsh <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef DIV_ZERO_CHK_EN
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_quot  <= '1;
              r_remo  <= dividend;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
`else
            r_state <= S_RUN;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_next_rem;
          r_qsh <= w_next_q;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_next_q;
            r_remo  <= w_next_rem;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;

endmodule

// File: tb/tb_restoring_div.sv
// Self-checking bench for restoring_div at WIDTH = 8; expected results queued at stimulus time.
module tb_restoring_div;

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       err;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  restoring_div #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.err = ZCHK; e.lat = ZCHK ? 1 : 9;
    end else begin
      e.q = a / b; e.r = a % b; e.err = 1'b0; e.lat = 9;
    end
    return e;
  endfunction

  function automatic logic [63:0] busy_exp(input int from, input int lat);
    logic [63:0] t = '0;
    for (int i = from; i < lat; i++) t[i] = 1'b1;
    return t;
  endfunction

  // Drive a start and let the accepting edge pass; returns 1 ns into cycle 1.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Sample busy each cycle until done; lat = cycle index of done, -1 on timeout.
  task automatic wait_done(input int cyc0, output int lat, output logic [63:0] trace);
    int cyc = cyc0;
    trace = '0;
    lat   = -1;
    while (cyc < 64) begin
      @(negedge clk);
      trace[cyc] = busy;
      if (done) begin
        lat = cyc;
        break;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, quotient, remainder} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0",
               busy, done, err, quotient, remainder);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_divide();
    logic [7:0] ta[4] = '{8'd100, 8'd255, 8'd5, 8'd255};
    logic [7:0] tb[4] = '{8'd7, 8'd1, 8'd9, 8'd255};
    logic [7:0] a, b;
    logic [63:0] tr;
    int lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin a = ta[i]; b = tb[i]; end
      else begin a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(1, 255)); end
      @(negedge clk);
      start_op(a, b, 1'b0);
      wait_done(1, lat, tr);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL divide_latency %0d/%0d: done in cycle %0d, want %0d", a, b, lat, e.lat);
      end
      n_cmp++;
      if ({quotient, remainder, err} !== {e.q, e.r, e.err}) begin
        n_fail++;
        $display("FAIL divide_result %0d/%0d: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=%b",
                 a, b, quotient, remainder, err, e.q, e.r, e.err);
      end
      n_cmp++;
      if (tr !== busy_exp(1, e.lat)) begin
        n_fail++;
        $display("FAIL divide_busy %0d/%0d: trace %h, want %h", a, b, tr, busy_exp(1, e.lat));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] tr;
    int lat;
    exp_t e;
    @(negedge clk);
    start_op(8'd37, 8'd0, 1'b0);
    wait_done(1, lat, tr);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL zero_latency: done in cycle %0d, want %0d", lat, e.lat);
    end
    n_cmp++;
    if ({quotient, remainder, err} !== {e.q, e.r, e.err}) begin
      n_fail++;
      $display("FAIL zero_result: got q=%h r=%0d err=%b, want q=%h r=%0d err=%b",
               quotient, remainder, err, e.q, e.r, e.err);
    end
    n_cmp++;
    if (tr !== busy_exp(1, e.lat)) begin
      n_fail++;
      $display("FAIL zero_busy: trace %h, want %h", tr, busy_exp(1, e.lat));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, quotient, remainder, err} !== {1'b0, e.q, e.r, e.err}) begin
      n_fail++;
      $display("FAIL zero_hold: got done=%b q=%h r=%0d err=%b, want done=0 q=%h r=%0d err=%b",
               done, quotient, remainder, err, e.q, e.r, e.err);
    end
  endtask

  task automatic test_start_busy();
    logic [63:0] tr;
    int lat, ndone;
    exp_t e;
    @(negedge clk);
    start_op(8'd100, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, lat, tr);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL busy_start_latency: done in cycle %0d, want %0d", lat, e.lat);
    end
    n_cmp++;
    if ({quotient, remainder, err} !== {e.q, e.r, e.err}) begin
      n_fail++;
      $display("FAIL busy_start_result: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=%b",
               quotient, remainder, err, e.q, e.r, e.err);
    end
    n_cmp++;
    if (tr !== busy_exp(5, e.lat)) begin
      n_fail++;
      $display("FAIL busy_start_busy: trace %h, want %h", tr, busy_exp(5, e.lat));
    end
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0 || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL busy_start_extra: got %0d extra done, q=%0d r=%0d, want 0, q=%0d r=%0d",
               ndone, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] tr;
    int lat, ndone;
    exp_t e;
    @(negedge clk);
    start_op(8'd200, 8'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if ({busy, done, err, quotient, remainder} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0",
               busy, done, err, quotient, remainder);
    end
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d done pulses, want 0", ndone);
    end
    start_op(8'd200, 8'd3, 1'b0);
    wait_done(1, lat, tr);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 9 || {quotient, remainder} !== {8'd66, 8'd2}) begin
      n_fail++;
      $display("FAIL reset_mid_after: got q=%0d r=%0d in cycle %0d, want q=66 r=2 in cycle 9",
               quotient, remainder, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] tr;
    int lat;
    exp_t e;
    @(negedge clk);
    start_op(8'd20, 8'd6, 1'b1);
    dividend = 8'd9; divisor = 8'd2;
    sb.push_back(model(8'd9, 8'd2));
    wait_done(1, lat, tr);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 9 || {quotient, remainder} !== {8'd3, 8'd2} || tr !== busy_exp(1, 9)) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%0d r=%0d cycle %0d busy %h, want q=%0d r=%0d cycle 9 busy %h",
               quotient, remainder, lat, tr, e.q, e.r, busy_exp(1, 9));
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, lat, tr);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 10 + e.lat) begin
      n_fail++;
      $display("FAIL b2b_latency: second done in cycle %0d, want %0d", lat, 10 + e.lat);
    end
    n_cmp++;
    if ({quotient, remainder, err} !== {e.q, e.r, e.err} || tr !== busy_exp(11, 19)) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%0d r=%0d err=%b busy %h, want q=%0d r=%0d err=%b busy %h",
               quotient, remainder, err, tr, e.q, e.r, e.err, busy_exp(11, 19));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
